instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the instruction decoder/controller. It owns the program counter, issues word reads to instruction memory over a req/gnt/rvalid interface, and buffers returned words in a small in-order FIFO. It presents one 32-bit instruction per cycle to the decoder with a valid/ready handshake, and supports redirect (branch/jump) with flush of stale fetches.

Parameters:
DWIDTH, 32, instruction width
AWIDTH, 16, PC/word-address width
RESET_PC, 0, PC value loaded on reset
FIFO_DEPTH, 2, fetch buffer entries; also the max outstanding plus buffered fetches (power of 2, >=2)
NOP_WORD, 32'h00078000, word driven on instr_out when not valid (fx field [18:15]=4'b1111)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
imem_req  out  1  read request to instruction memory
imem_addr  out  AWIDTH  word address of request, valid while imem_req=1
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid; in order, at least 1 cycle after its gnt
imem_rdata  in  DWIDTH  read data
redirect  in  1  1-cycle pulse: restart fetch at redirect_pc
redirect_pc  in  AWIDTH  redirect target
instr_valid  out  1  instr_out/instr_pc hold a fetched instruction
instr_out  out  DWIDTH  instruction to decoder (in32)
instr_pc  out  AWIDTH  address of instr_out
instr_ready  in  1  decoder accepts instr_out this cycle
busy  out  1  1 while state is S_FLUSH

Behaviour:
- Reset (async, while rst=1): pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state=S_BOOT; imem_req=0, instr_valid=0, instr_out=NOP_WORD, instr_pc=0, busy=0.
- FSM: S_BOOT -> S_RUN on the first clock after rst deasserts (no request in S_BOOT). S_RUN -> S_FLUSH on redirect when outstanding (after this cycle's gnt/rvalid) > 0; otherwise stays S_RUN with pc=redirect_pc. S_FLUSH -> S_RUN when discard reaches 0.
- Request: in S_RUN with no redirect, imem_req=1 iff fifo_count+outstanding < FIFO_DEPTH; imem_addr=pc (combinational from register). On req&gnt: pc<=pc+1 (wraps modulo 2^AWIDTH), outstanding+1. Req stays asserted with the same addr until gnt. imem_req=0 in S_BOOT/S_FLUSH and in any cycle with redirect=1.
- Response: on imem_rvalid, outstanding-1. If discard>0: drop data, discard-1. Else push {imem_rdata, fetch_pc} into FIFO; fetch_pc tracked per entry (pc of request). gnt and rvalid in the same cycle: outstanding unchanged.
- Output: instr_valid = FIFO non-empty and state != S_FLUSH; instr_out/instr_pc = head entry, else NOP_WORD/0. Pop on instr_valid&instr_ready. Push and pop same cycle when full: legal, count unchanged. Zero-latency bypass not required: minimum latency gnt->instr_valid is rvalid cycle +1.
- Redirect (priority over all else in that cycle): FIFO cleared, pc<=redirect_pc, discard<=outstanding (including a gnt in the same cycle, minus an rvalid in the same cycle). A pop handshake coinciding with redirect still counts as consumed by the decoder. Redirect during S_FLUSH updates pc and adds any new gnt to discard; stays in S_FLUSH.
- Protocol error: rvalid with outstanding=0 is ignored (no push, no underflow).
- Reset mid-operation: all state cleared immediately; in-flight responses arriving after reset are ignored by the rule above.

Test Plan:
- Reset then free-run, gnt always 1, rvalid 1 cycle after gnt, instr_ready=1, imem_rdata=addr -> imem_addr 0,1,2,...; instr_out 0,1,2 in order, instr_pc matches, one per cycle sustained after pipeline fill.
- instr_ready=0 for 10 cycles -> FIFO fills to 2, imem_req drops to 0, instr_out holds word 0 stable with instr_valid=1; on release words stream with no loss/duplication.
- gnt held 0 for 5 cycles with req=1 -> imem_addr stable at same value, pc not incremented.
- Redirect to 0x0100 with 2 outstanding -> busy=1, the 2 stale responses dropped, instr_valid=0 until first word from 0x0100; instr_pc=0x0100.
- pc=0xFFFF (AWIDTH=16) -> next request addr 0x0000.
- Assert rst mid-stream with outstanding=2, then 2 late rvalids -> outputs at reset values, late data not presented, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: memory-side req/gnt/rvalid bus and decoder-side valid/ready bus of the fetch unit.
interface instr_fetch_unit_if #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 32
);
  logic              imem_req;
  logic [AWIDTH-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DWIDTH-1:0] imem_rdata;
  logic              redirect;
  logic [AWIDTH-1:0] redirect_pc;
  logic              instr_valid;
  logic [DWIDTH-1:0] instr_out;
  logic [AWIDTH-1:0] instr_pc;
  logic              instr_ready;
  logic              busy;
  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc, busy,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc, busy,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner issuing in-order word fetches into a small FIFO feeding the decoder, with redirect/flush.
module instr_fetch_unit #(
  parameter int                AWIDTH     = 16,
  parameter int                DWIDTH     = 32,
  parameter logic [AWIDTH-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [DWIDTH-1:0] NOP_WORD   = 32'h00078000
) (
  input logic clk,
  input logic rst,
  instr_fetch_unit_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;
  state_t            r_state, w_state_n;
  logic [AWIDTH-1:0] r_pc, r_rsp_pc;
  logic [CW-1:0]     r_out, r_disc, r_cnt, w_out_n, w_disc_n;
  logic [PW-1:0]     r_wp, r_rp;
  logic [DWIDTH-1:0] r_data [FIFO_DEPTH];
  logic [AWIDTH-1:0] r_fpc  [FIFO_DEPTH];
  logic              w_acc, w_rv, w_push, w_pop;
  assign w_acc    = bus.imem_req & bus.imem_gnt;
  // responses with nothing outstanding (e.g. left over from before a reset) are ignored
  assign w_rv     = bus.imem_rvalid & (r_out != '0);
  assign w_push   = w_rv & (r_disc == '0) & ~bus.redirect;
  assign w_pop    = bus.instr_valid & bus.instr_ready;
  assign w_out_n  = r_out + CW'(w_acc) - CW'(w_rv);
  assign w_disc_n = bus.redirect ? w_out_n : r_disc - CW'(w_rv && r_disc != '0);
  always_comb begin
    w_state_n       = r_state;
    if (r_state == S_BOOT) w_state_n = S_RUN;
    else if (r_state == S_RUN) w_state_n = (bus.redirect && w_out_n != '0) ? S_FLUSH : S_RUN;
    else w_state_n = (w_disc_n == '0) ? S_RUN : S_FLUSH;
    bus.imem_req    = (r_state == S_RUN) && !bus.redirect &&
                      ({1'b0, r_cnt} + {1'b0, r_out} < (CW+1)'(FIFO_DEPTH));
    bus.imem_addr   = r_pc;
    bus.busy        = r_state == S_FLUSH;
    bus.instr_valid = (r_cnt != '0) && (r_state != S_FLUSH);
    bus.instr_out   = bus.instr_valid ? r_data[r_rp] : NOP_WORD;
    bus.instr_pc    = bus.instr_valid ? r_fpc[r_rp] : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_BOOT;
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_out    <= '0;
      r_disc   <= '0;
      r_cnt    <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
    end else begin
      r_state <= w_state_n;
      r_out   <= w_out_n;
      r_disc  <= w_disc_n;
      if (bus.redirect) begin
        r_pc     <= bus.redirect_pc;
        r_rsp_pc <= bus.redirect_pc;
        r_cnt    <= '0;
        r_wp     <= '0;
        r_rp     <= '0;
      end else begin
        if (w_acc) r_pc <= r_pc + 1'b1;
        if (w_push) begin
          r_wp     <= r_wp + 1'b1;
          r_rsp_pc <= r_rsp_pc + 1'b1;
        end
        if (w_pop) r_rp <= r_rp + 1'b1;
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end
  // the pc of each kept response is implied by order: next expected pc advances per push
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wp] <= bus.imem_rdata;
      r_fpc[r_wp]  <= r_rsp_pc;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: memory model plus scoreboard of expected instructions, driven by a phase table and hand sequences.
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h00078000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  instr_fetch_unit_if #(.AWIDTH(16), .DWIDTH(32)) bus ();
  instr_fetch_unit #(.AWIDTH(16), .DWIDTH(32), .RESET_PC(16'h0000), .FIFO_DEPTH(2), .NOP_WORD(NOP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  typedef struct {logic [15:0] a; int gc; bit stale;} fl_t;
  typedef struct {int n; bit gnt; bit ready; bit rsp; bit redir; logic [15:0] rpc; int exp_req; int exp_valid; int exp_busy;} phase_t;
  fl_t         inflight[$];
  logic [15:0] expq[$];
  fl_t         rsp;
  logic [15:0] exp_addr;
  phase_t      tbl[12];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int pops = 0;
  bit gnt_en, ready_en, rsp_en, redir_req;
  logic [15:0] redir_target;
  function automatic logic [31:0] word_of(input logic [15:0] a);
    return {~a, a};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic cycle();
    bit have;
    @(posedge clk);
    #1;
    cyc++;
    have = 0;
    bus.redirect    = redir_req;
    bus.redirect_pc = redir_target;
    redir_req       = 0;
    bus.imem_gnt    = gnt_en;
    bus.instr_ready = ready_en;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    if (rsp_en && inflight.size() > 0 && inflight[0].gc < cyc) begin
      rsp = inflight.pop_front();
      have = 1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = word_of(rsp.a);
    end
    #1;
    if (bus.redirect && bus.imem_req) check("req_during_redirect", 32'(bus.imem_req), 32'd0);
    if (bus.imem_req) check("imem_addr", 32'(bus.imem_addr), 32'(exp_addr));
    if (bus.imem_req && bus.imem_gnt) begin
      inflight.push_back('{a: bus.imem_addr, gc: cyc, stale: 1'b0});
      exp_addr = exp_addr + 16'd1;
    end
    if (bus.instr_valid) begin
      if (expq.size() == 0) check("valid_without_expected", 32'(bus.instr_valid), 32'd0);
      else begin
        check("instr_pc", 32'(bus.instr_pc), 32'(expq[0]));
        check("instr_out", bus.instr_out, word_of(expq[0]));
        if (bus.instr_ready) begin
          void'(expq.pop_front());
          pops++;
        end
      end
    end else begin
      check("idle_instr_out", bus.instr_out, NOP);
      check("idle_instr_pc", 32'(bus.instr_pc), 32'd0);
    end
    if (have && !rsp.stale && !bus.redirect) expq.push_back(rsp.a);
    if (bus.redirect) begin
      expq.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      exp_addr = bus.redirect_pc;
    end
  endtask
  initial begin
    tbl[0]  = '{20, 1, 1, 1, 0, 16'h0000, -1, -1, 0};
    tbl[1]  = '{10, 1, 0, 1, 0, 16'h0000,  0,  1, 0};
    tbl[2]  = '{6,  0, 1, 1, 0, 16'h0000,  1,  0, 0};
    tbl[3]  = '{3,  1, 1, 0, 0, 16'h0000,  0,  0, 0};
    tbl[4]  = '{1,  1, 1, 0, 1, 16'h0100,  0,  0, 0};
    tbl[5]  = '{1,  1, 1, 0, 0, 16'h0000,  0,  0, 1};
    tbl[6]  = '{2,  1, 1, 1, 0, 16'h0000,  0,  0, 1};
    tbl[7]  = '{1,  1, 1, 1, 0, 16'h0000,  1,  0, 0};
    tbl[8]  = '{1,  1, 1, 1, 0, 16'h0000,  1,  0, 0};
    tbl[9]  = '{1,  1, 1, 1, 0, 16'h0000,  0,  1, 0};
    tbl[10] = '{1,  1, 1, 1, 1, 16'hFFFE,  0,  1, 0};
    tbl[11] = '{12, 1, 1, 1, 0, 16'h0000, -1, -1, 0};
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0;
    bus.redirect = 0; bus.redirect_pc = '0; bus.instr_ready = 0;
    gnt_en = 0; ready_en = 0; rsp_en = 0; redir_req = 0; redir_target = '0;
    exp_addr = 16'h0000;
    #12;
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_out", bus.instr_out, NOP);
    check("rst_pc", 32'(bus.instr_pc), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    for (int p = 0; p < 12; p++) begin
      gnt_en = tbl[p].gnt; ready_en = tbl[p].ready; rsp_en = tbl[p].rsp;
      for (int c = 0; c < tbl[p].n; c++) begin
        if (c == 0 && tbl[p].redir) begin
          redir_req = 1; redir_target = tbl[p].rpc;
        end
        cycle();
      end
      if (tbl[p].exp_req >= 0) check($sformatf("phase%0d_req", p), 32'(bus.imem_req), 32'(tbl[p].exp_req));
      if (tbl[p].exp_valid >= 0) check($sformatf("phase%0d_valid", p), 32'(bus.instr_valid), 32'(tbl[p].exp_valid));
      if (tbl[p].exp_busy >= 0) check($sformatf("phase%0d_busy", p), 32'(bus.busy), 32'(tbl[p].exp_busy));
    end
    check("wrap_addr", 32'(exp_addr < 16'h0100), 32'd1);
    rsp_en = 0; gnt_en = 1; ready_en = 1;
    repeat (4) cycle();
    check("pre_reset_outstanding", 32'(inflight.size()), 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    gnt_en = 0;
    bus.imem_gnt = 0;
    #1;
    check("midrst_req", 32'(bus.imem_req), 32'd0);
    check("midrst_valid", 32'(bus.instr_valid), 32'd0);
    check("midrst_out", bus.instr_out, NOP);
    check("midrst_pc", 32'(bus.instr_pc), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    expq.delete();
    foreach (inflight[i]) inflight[i].stale = 1'b1;
    exp_addr = 16'h0000;
    repeat (2) cycle();
    rst = 1'b0;
    rsp_en = 1;
    repeat (4) cycle();
    check("late_rvalid_drained", 32'(inflight.size()), 32'd0);
    check("post_rst_valid", 32'(bus.instr_valid), 32'd0);
    check("post_rst_req", 32'(bus.imem_req), 32'd1);
    check("post_rst_addr", 32'(bus.imem_addr), 32'd0);
    pops = 0;
    gnt_en = 1;
    repeat (12) cycle();
    check("post_rst_streaming", 32'(pops >= 4), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
